// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM states, default width
// and the bit-counter sizing helper.
package serial_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter width needed to index WIDTH bits, never narrower than one bit
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// Full-subtractor built from two half-subtractors plus an OR on the borrows.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic d1;
  logic b1;
  logic b2;

  half_subtractor u_hs_xy (
    .a    (x),
    .b    (y),
    .d    (d1),
    .bout (b1)
  );

  half_subtractor u_hs_bin (
    .a    (d1),
    .b    (bin),
    .d    (d),
    .bout (b2)
  );

  assign bout = b1 | b2;

endmodule

// File: rtl/half_subtractor.sv
// Half-subtractor cell: difference and borrow of a - b for single bits.
module half_subtractor (
  input  logic a,
  input  logic b,
  output logic d,
  output logic bout
);

  assign d    = a ^ b;
  assign bout = ~a & b;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor computing x - y LSB-first, one bit per clock,
// with a registered borrow chain and a start/busy/done handshake.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             b
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] sx;
  logic [WIDTH-1:0] sy;
  logic [WIDTH-1:0] sd;
  logic [WIDTH-1:0] sd_next;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             diff;
  logic             bout;

  full_subtractor u_fs (
    .x    (sx[0]),
    .y    (sy[0]),
    .bin  (br),
    .d    (diff),
    .bout (bout)
  );

  // The new difference bit enters from the MSB so the LSB arrives last in bit 0
  generate
    if (WIDTH == 1) begin : g_w1
      assign sd_next = diff;
    end else begin : g_wn
      assign sd_next = {diff, sd[WIDTH-1:1]};
    end
  endgenerate

  // Sequencing FSM with shift registers, borrow, counter and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      d     <= '0;
      b     <= 1'b0;
      sx    <= '0;
      sy    <= '0;
      sd    <= '0;
      br    <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sx    <= x;
            sy    <= y;
            sd    <= '0;
            br    <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          sx  <= sx >> 1;
          sy  <= sy >> 1;
          sd  <= sd_next;
          br  <= bout;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            d     <= sd_next;
            b     <= bout;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
